// File: rtl/axilite_reg_bridge.sv
// AXI-Lite slave to single-port register bridge with round-robin read/write arbitration,
// address-range decode and access timeout. Optional error responses: AXIL_REG_BRIDGE_ERR_RESP_EN.
module axilite_reg_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 40,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int REG_COUNT  = 64,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic [STRB_WIDTH-1:0] reg_wr_strb,
  output logic                  reg_wr_en,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  input  logic                  reg_wait,
  input  logic                  reg_ack
);

  localparam int AL = $clog2(STRB_WIDTH);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_REG_BRIDGE_ERR_RESP_EN
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
`else
  localparam logic [1:0] RESP_SLVERR = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b00;
`endif

  typedef enum logic [1:0] {PORT_IDLE, PORT_ACCESS, PORT_RESP} port_state_t;

  port_state_t           state;
  logic                  ready_en, aw_full, w_full, ar_full, cur_wr, last_wr;
  logic [ADDR_WIDTH-1:0] aw_addr, ar_addr, sel_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic [CW-1:0]         cnt;
  logic                  wr_req, rd_req, grant_wr, in_range, timeout_hit;
  logic                  unused_prot;

  assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

  // ready_en keeps all readies low until the first edge after reset release
  assign s_axil_awready = ready_en & ~aw_full;
  assign s_axil_wready  = ready_en & ~w_full;
  assign s_axil_arready = ready_en & ~ar_full;

  assign wr_req      = aw_full & w_full;
  assign rd_req      = ar_full;
  assign grant_wr    = wr_req & (~rd_req | ~last_wr);
  assign sel_addr    = grant_wr ? aw_addr : ar_addr;
  assign in_range    = (sel_addr >> AL) < ADDR_WIDTH'(REG_COUNT);
  assign timeout_hit = (TIMEOUT != 0) && !reg_wait && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= PORT_IDLE;
      ready_en      <= 1'b0;
      aw_full       <= 1'b0;
      w_full        <= 1'b0;
      ar_full       <= 1'b0;
      aw_addr       <= '0;
      ar_addr       <= '0;
      w_data        <= '0;
      w_strb        <= '0;
      cur_wr        <= 1'b0;
      last_wr       <= 1'b0;
      cnt           <= '0;
      reg_addr      <= '0;
      reg_wr_data   <= '0;
      reg_wr_strb   <= '0;
      reg_wr_en     <= 1'b0;
      reg_rd_en     <= 1'b0;
      s_axil_bresp  <= RESP_OKAY;
      s_axil_bvalid <= 1'b0;
      s_axil_rdata  <= '0;
      s_axil_rresp  <= RESP_OKAY;
      s_axil_rvalid <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (s_axil_awvalid && s_axil_awready) begin
        aw_full <= 1'b1;
        aw_addr <= s_axil_awaddr;
      end
      if (s_axil_wvalid && s_axil_wready) begin
        w_full <= 1'b1;
        w_data <= s_axil_wdata;
        w_strb <= s_axil_wstrb;
      end
      if (s_axil_arvalid && s_axil_arready) begin
        ar_full <= 1'b1;
        ar_addr <= s_axil_araddr;
      end

      case (state)
        PORT_IDLE: begin
          if (wr_req || rd_req) begin
            cur_wr  <= grant_wr;
            last_wr <= grant_wr;
            cnt     <= '0;
            if (in_range) begin
              state       <= PORT_ACCESS;
              reg_addr    <= {sel_addr[ADDR_WIDTH-1:AL], {AL{1'b0}}};
              reg_wr_data <= w_data;
              reg_wr_strb <= w_strb;
              reg_wr_en   <= grant_wr;
              reg_rd_en   <= ~grant_wr;
            end else if (grant_wr) begin
              state         <= PORT_RESP;
              s_axil_bvalid <= 1'b1;
              s_axil_bresp  <= RESP_DECERR;
            end else begin
              state         <= PORT_RESP;
              s_axil_rvalid <= 1'b1;
              s_axil_rresp  <= RESP_DECERR;
              s_axil_rdata  <= '0;
            end
          end
        end
        PORT_ACCESS: begin
          // ack is checked first so it wins over a same-cycle timeout
          if (reg_ack || timeout_hit) begin
            state     <= PORT_RESP;
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            if (cur_wr) begin
              s_axil_bvalid <= 1'b1;
              s_axil_bresp  <= reg_ack ? RESP_OKAY : RESP_SLVERR;
            end else begin
              s_axil_rvalid <= 1'b1;
              s_axil_rresp  <= reg_ack ? RESP_OKAY : RESP_SLVERR;
              s_axil_rdata  <= reg_ack ? reg_rd_data : '0;
            end
          end else if (!reg_wait) begin
            cnt <= cnt + 1'b1;
          end
        end
        PORT_RESP: begin
          if (cur_wr && s_axil_bvalid && s_axil_bready) begin
            state         <= PORT_IDLE;
            s_axil_bvalid <= 1'b0;
            aw_full       <= 1'b0;
            w_full        <= 1'b0;
          end else if (!cur_wr && s_axil_rvalid && s_axil_rready) begin
            state         <= PORT_IDLE;
            s_axil_rvalid <= 1'b0;
            ar_full       <= 1'b0;
          end
        end
        default: state <= PORT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axilite_reg_bridge.sv
// Self-checking bench for axilite_reg_bridge: vector table plus hand sequences,
// with scoreboard queues for register accesses and B/R responses.
module tb_axilite_reg_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [39:0] s_axil_awaddr = '0;
  logic [2:0]  s_axil_awprot = '0;
  logic        s_axil_awvalid = 1'b0;
  logic        s_axil_awready;
  logic [31:0] s_axil_wdata = '0;
  logic [3:0]  s_axil_wstrb = '0;
  logic        s_axil_wvalid = 1'b0;
  logic        s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid;
  logic        s_axil_bready = 1'b1;
  logic [39:0] s_axil_araddr = '0;
  logic [2:0]  s_axil_arprot = '0;
  logic        s_axil_arvalid = 1'b0;
  logic        s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready = 1'b1;
  logic [39:0] reg_addr;
  logic [31:0] reg_wr_data;
  logic [3:0]  reg_wr_strb;
  logic        reg_wr_en, reg_rd_en;
  logic [31:0] reg_rd_data = '0;
  logic        reg_wait = 1'b0;
  logic        reg_ack = 1'b0;

  axilite_reg_bridge dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .reg_addr(reg_addr), .reg_wr_data(reg_wr_data), .reg_wr_strb(reg_wr_strb),
    .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data),
    .reg_wait(reg_wait), .reg_ack(reg_ack)
  );

  always #5 clk = ~clk;

`ifdef AXIL_REG_BRIDGE_ERR_RESP_EN
  localparam logic [1:0] EXP_DEC = 2'b11;
  localparam logic [1:0] EXP_SLV = 2'b10;
`else
  localparam logic [1:0] EXP_DEC = 2'b00;
  localparam logic [1:0] EXP_SLV = 2'b00;
`endif

  typedef struct {
    logic        is_wr;
    logic [39:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          cyc;   // 0: enable length not checked
  } acc_t;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
  } rsp_t;

  typedef struct {
    logic        is_wr;
    logic [39:0] addr;
    logic [31:0] data;   // write data, or register read data for reads
    logic [3:0]  strb;
    int          ack_delay;
    int          wait_cyc;
    logic        acc;
    int          cyc;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  acc_t exp_acc_q[$];
  rsp_t exp_b_q[$];
  rsp_t exp_r_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int both_hi = 0;
  int ack_delay = 0;    // -1: never ack
  int wait_cyc = 0;
  logic [31:0] rd_val = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // register slave model plus access scoreboard
  initial begin : reg_slave
    int en_cnt;
    acc_t cur;
    acc_t e;
    en_cnt = 0;
    cur = '{1'b0, '0, '0, '0, 0};
    forever begin
      @(negedge clk);
      if (reg_wr_en && reg_rd_en) both_hi++;
      if (reg_wr_en || reg_rd_en) begin
        if (en_cnt == 0) cur = '{reg_wr_en, reg_addr, reg_wr_data, reg_wr_strb, 0};
        en_cnt++;
        reg_ack = (ack_delay >= 0) && (en_cnt == ack_delay + 1);
        reg_wait = (en_cnt <= wait_cyc);
        reg_rd_data = rd_val;
      end else begin
        if (en_cnt != 0) begin
          if (exp_acc_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL acc_unexpected: got access addr %0h, none expected", cur.addr);
          end else begin
            e = exp_acc_q.pop_front();
            check("acc_is_wr", cur.is_wr, e.is_wr);
            check("acc_addr", cur.addr, e.addr);
            if (e.cyc != 0) check("acc_en_cycles", en_cnt, e.cyc);
            if (e.is_wr) begin
              check("acc_wr_data", cur.data, e.data);
              check("acc_wr_strb", cur.strb, e.strb);
            end
          end
        end
        en_cnt = 0;
        reg_ack = 1'b0;
        reg_wait = 1'b0;
        reg_rd_data = ~rd_val;
      end
    end
  end

  // response scoreboard: ready only changes just after posedge, so a negedge sample predicts the handshake
  initial begin : rsp_mon
    rsp_t e;
    forever begin
      @(negedge clk);
      if (s_axil_bvalid && s_axil_bready) begin
        if (exp_b_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL b_unexpected: got bresp %0h, none expected", s_axil_bresp);
        end else begin
          e = exp_b_q.pop_front();
          check("bresp", s_axil_bresp, e.resp);
        end
      end
      if (s_axil_rvalid && s_axil_rready) begin
        if (exp_r_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL r_unexpected: got rdata %0h, none expected", s_axil_rdata);
        end else begin
          e = exp_r_q.pop_front();
          check("rresp", s_axil_rresp, e.resp);
          check("rdata", s_axil_rdata, e.data);
        end
      end
    end
  end

  task automatic send_aw(input logic [39:0] a);
    int t = 0;
    @(negedge clk);
    s_axil_awaddr = a;
    s_axil_awprot = 3'b010;
    s_axil_awvalid = 1'b1;
    while (!s_axil_awready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) bound_fail("aw_accept");
    @(posedge clk);
    #1 s_axil_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int t = 0;
    @(negedge clk);
    s_axil_wdata = d;
    s_axil_wstrb = s;
    s_axil_wvalid = 1'b1;
    while (!s_axil_wready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) bound_fail("w_accept");
    @(posedge clk);
    #1 s_axil_wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [39:0] a);
    int t = 0;
    @(negedge clk);
    s_axil_araddr = a;
    s_axil_arprot = 3'b001;
    s_axil_arvalid = 1'b1;
    while (!s_axil_arready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) bound_fail("ar_accept");
    @(posedge clk);
    #1 s_axil_arvalid = 1'b0;
  endtask

  task automatic wr_txn(input logic [39:0] a, input logic [31:0] d, input logic [3:0] s);
    fork
      send_aw(a);
      send_w(d, s);
    join
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_acc_q.size() + exp_b_q.size() + exp_r_q.size()) != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain_outstanding", exp_acc_q.size() + exp_b_q.size() + exp_r_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs[10];
    int t;
    vecs[0] = '{1'b1, 40'h8,            32'hDEADBEEF, 4'hF,  0,  0, 1'b1,  1, 2'b00,   32'h0};
    vecs[1] = '{1'b0, 40'h8,            32'h12345678, 4'h0,  3,  0, 1'b1,  4, 2'b00,   32'h12345678};
    vecs[2] = '{1'b1, 40'hFC,           32'hA5A50F0F, 4'h5,  1,  0, 1'b1,  2, 2'b00,   32'h0};
    vecs[3] = '{1'b0, 40'hFC,           32'hCAFEF00D, 4'h0,  0,  0, 1'b1,  1, 2'b00,   32'hCAFEF00D};
    vecs[4] = '{1'b1, 40'h100,          32'h55AA55AA, 4'hF,  0,  0, 1'b0,  0, EXP_DEC, 32'h0};
    vecs[5] = '{1'b0, 40'h100,          32'h77777777, 4'h0,  0,  0, 1'b0,  0, EXP_DEC, 32'h0};
    vecs[6] = '{1'b0, 40'h4,            32'h11111111, 4'h0, -1,  0, 1'b1, 16, EXP_SLV, 32'h0};
    vecs[7] = '{1'b1, 40'h10,           32'h22222222, 4'hF, -1, 10, 1'b1, 26, EXP_SLV, 32'h0};
    vecs[8] = '{1'b0, 40'hB,            32'h33333333, 4'h0,  2,  5, 1'b1,  3, 2'b00,   32'h33333333};
    vecs[9] = '{1'b1, 40'hFF_0000_0004, 32'h00000044, 4'hF,  0,  0, 1'b0,  0, EXP_DEC, 32'h0};

    // reset state
    #2 rst = 1'b1;
    #1;
    check("rst_awready", s_axil_awready, 0);
    check("rst_wready", s_axil_wready, 0);
    check("rst_arready", s_axil_arready, 0);
    check("rst_bvalid", s_axil_bvalid, 0);
    check("rst_rvalid", s_axil_rvalid, 0);
    check("rst_reg_en", {reg_wr_en, reg_rd_en}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("rel_awready_low", s_axil_awready, 0);
    @(posedge clk);
    #1 check("rel_readies_up", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);

    // minimum-latency write
    ack_delay = 0; wait_cyc = 0;
    exp_acc_q.push_back('{1'b1, 40'h8, 32'hDEADBEEF, 4'hF, 1});
    exp_b_q.push_back('{2'b00, 32'h0});
    wr_txn(40'h8, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    check("lat_en_accept_cycle", reg_wr_en, 0);
    next_cyc();
    check("lat_en_next_cycle", reg_wr_en, 1);
    check("lat_reg_addr", reg_addr, 40'h8);
    check("lat_bvalid_early", s_axil_bvalid, 0);
    next_cyc();
    check("lat_en_dropped", reg_wr_en, 0);
    check("lat_bvalid", s_axil_bvalid, 1);
    drain();

    // AW ahead of W: channels captured independently
    exp_acc_q.push_back('{1'b1, 40'h20, 32'h01020304, 4'hF, 1});
    exp_b_q.push_back('{2'b00, 32'h0});
    send_aw(40'h20);
    @(negedge clk);
    check("indep_awready_full", s_axil_awready, 0);
    check("indep_wready_free", s_axil_wready, 1);
    next_cyc();
    check("indep_no_access", reg_wr_en, 0);
    send_w(32'h01020304, 4'hF);
    drain();

    // vector table
    for (int i = 0; i < 10; i++) begin
      ack_delay = vecs[i].ack_delay;
      wait_cyc = vecs[i].wait_cyc;
      rd_val = vecs[i].is_wr ? 32'h0 : vecs[i].data;
      if (vecs[i].acc)
        exp_acc_q.push_back('{vecs[i].is_wr, vecs[i].addr & ~40'h3, vecs[i].data, vecs[i].strb, vecs[i].cyc});
      if (vecs[i].is_wr) begin
        exp_b_q.push_back('{vecs[i].resp, 32'h0});
        wr_txn(vecs[i].addr, vecs[i].data, vecs[i].strb);
      end else begin
        exp_r_q.push_back('{vecs[i].resp, vecs[i].rdata});
        send_ar(vecs[i].addr);
      end
      drain();
    end

    // round-robin: after a read, simultaneous requests go W then R
    ack_delay = 0; wait_cyc = 0; rd_val = 32'h0BADCAFE;
    exp_acc_q.push_back('{1'b0, 40'h60, 32'h0, 4'h0, 1});
    exp_r_q.push_back('{2'b00, 32'h0BADCAFE});
    send_ar(40'h60);
    drain();
    for (int k = 0; k < 2; k++) begin
      exp_acc_q.push_back('{1'b1, 40'h64 + 40'(8*k), 32'hA0 + 32'(k), 4'hF, 1});
      exp_acc_q.push_back('{1'b0, 40'h68 + 40'(8*k), 32'h0, 4'h0, 1});
      exp_b_q.push_back('{2'b00, 32'h0});
      exp_r_q.push_back('{2'b00, 32'h0BADCAFE});
      fork
        wr_txn(40'h64 + 40'(8*k), 32'hA0 + 32'(k), 4'hF);
        send_ar(40'h68 + 40'(8*k));
      join
      drain();
    end
    // after a lone write, simultaneous requests go R then W
    exp_acc_q.push_back('{1'b1, 40'h80, 32'hB0, 4'h3, 1});
    exp_b_q.push_back('{2'b00, 32'h0});
    wr_txn(40'h80, 32'hB0, 4'h3);
    drain();
    exp_acc_q.push_back('{1'b0, 40'h88, 32'h0, 4'h0, 1});
    exp_acc_q.push_back('{1'b1, 40'h84, 32'hB4, 4'hC, 1});
    exp_b_q.push_back('{2'b00, 32'h0});
    exp_r_q.push_back('{2'b00, 32'h0BADCAFE});
    fork
      wr_txn(40'h84, 32'hB4, 4'hC);
      send_ar(40'h88);
    join
    drain();

    // reset mid-access: abort with no response
    ack_delay = -1;
    exp_acc_q.push_back('{1'b1, 40'h50, 32'h5050, 4'hF, 0});
    wr_txn(40'h50, 32'h5050, 4'hF);
    repeat (3) next_cyc();
    check("abort_in_access", reg_wr_en, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_en_drop", {reg_wr_en, reg_rd_en}, 0);
    check("abort_readies", {s_axil_awready, s_axil_wready, s_axil_arready}, 0);
    check("abort_valids", {s_axil_bvalid, s_axil_rvalid}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 check("abort_readies_back", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);

    // post-reset write with bvalid held until bready
    ack_delay = 0;
    s_axil_bready = 1'b0;
    exp_acc_q.push_back('{1'b1, 40'h54, 32'h5454, 4'hF, 1});
    exp_b_q.push_back('{2'b00, 32'h0});
    wr_txn(40'h54, 32'h5454, 4'hF);
    t = 0;
    while (!s_axil_bvalid && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) bound_fail("post_rst_bvalid");
    repeat (3) next_cyc();
    check("bvalid_held", s_axil_bvalid, 1);
    @(posedge clk);
    #1 s_axil_bready = 1'b1;
    drain();

    check("never_both_enables", both_hi, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
